// File: rtl/rx_fifo_pkg.sv
// Common parameters for the receive FIFO, taken from the shared UART defines.
`include "uart_defines.sv"

package rx_fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = `DATA_WIDTH;
   localparam int DEFAULT_DEPTH      = `FIFO_DEPTH;

   // Entry layout: {parity_err, stop_err, data}
   localparam int FLAG_BITS = 2;

endpackage

// File: rtl/rx_fifo_ram.sv
// Storage array for the receive FIFO: one synchronous write port, one asynchronous read port.
module rx_fifo_ram #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: storage is deliberately not reset; validity is tracked by the pointers,
   // and a reset-free array maps onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_defines.sv
// Shared UART receiver defaults: character width and receive FIFO depth.
`ifndef UART_DEFINES_SV
`define UART_DEFINES_SV

`define DATA_WIDTH 8
`define FIFO_DEPTH 16

`endif

// File: rtl/rx_fifo.sv
// Receive FIFO holding each character with its parity/stop error flags; first-word fall-through.
module rx_fifo
   import rx_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_valid,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic                      wr_parity_err,
   input  logic                      wr_stop_err,
   input  logic                      rd_ready,
   output logic                      rd_valid,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      rd_parity_err,
   output logic                      rd_stop_err,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty,
   output logic                      overrun,
   input  logic                      overrun_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_WIDTH + FLAG_BITS;

   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overrun_q, overrun_d;
   logic          wr_fire, rd_fire;
   logic [EW-1:0] rd_entry;

   // Extra MSB on the pointers separates full (laps differ) from empty (identical).
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign rd_fire = !empty && rd_ready;
   assign wr_fire = wr_valid && (!full || rd_fire);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;

      if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;

      case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A dropped frame outranks a clear arriving on the same edge.
      if (wr_valid && !wr_fire) overrun_d = 1'b1;
      else if (overrun_clr)     overrun_d = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   rx_fifo_ram #(
      .WIDTH (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_fire),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i ({wr_parity_err, wr_stop_err, wr_data}),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rd_entry)
   );

   assign rd_valid      = !empty;
   assign rd_parity_err = rd_entry[EW-1];
   assign rd_stop_err   = rd_entry[EW-2];
   assign rd_data       = rd_entry[DATA_WIDTH-1:0];
   assign count         = count_q;
   assign overrun       = overrun_q;

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (8), received character width.
REQ-002 Parameter DEPTH, default 16, entry count; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_valid  input  1  one-cycle strobe from the receiver: frame complete.
REQ-006 wr_data  input  DATA_WIDTH  received character, qualified by wr_valid.
REQ-007 wr_parity_err  input  1  parity error for the frame, qualified by wr_valid.
REQ-008 wr_stop_err  input  1  stop-bit error for the frame, qualified by wr_valid.
REQ-009 rd_ready  input  1  consumer accepts the head entry.
REQ-010 rd_valid  output  1  head entry present.
REQ-011 rd_data  output  DATA_WIDTH  head character.
REQ-012 rd_parity_err  output  1  head entry parity flag.
REQ-013 rd_stop_err  output  1  head entry stop-bit flag.
REQ-014 count  output  log2(DEPTH)+1  occupied entries, 0..DEPTH.
REQ-015 full  output  1  count == DEPTH.
REQ-016 empty  output  1  count == 0.
REQ-017 overrun  output  1  sticky: a frame was dropped because the FIFO was full.
REQ-018 overrun_clr  input  1  synchronous clear of overrun.

Function
REQ-019 Each entry SHALL store {parity_err, stop_err, data}, DATA_WIDTH+2 bits.
REQ-020 Write accepted when wr_valid=1 and (full=0, or a read fires in the same cycle).
- Entry stored at wr_ptr.
- wr_ptr increments.
REQ-021 Read fires when rd_valid=1 and rd_ready=1; rd_ptr increments on that edge.
REQ-022 Read-side behaviour:
- rd_valid SHALL equal !empty.
- rd_data, rd_parity_err and rd_stop_err SHALL show the entry at rd_ptr combinationally (first-word fall-through).
REQ-023 Latency: a write accepted at edge N SHALL give rd_valid=1 after edge N when the FIFO was empty; no extra cycle.
REQ-024 Pointers SHALL be log2(DEPTH)+1 bits.
- Index = low bits; wrap from DEPTH-1 to 0 with the MSB toggling.
- full = index equal and MSB different; empty = pointers equal.
REQ-025 count SHALL change on each edge as follows:
- +1 on write only.
- -1 on read only.
- Unchanged on both or neither.
REQ-026 Write while full with no read in the same cycle:
- The frame SHALL be dropped.
- Storage, pointers and count SHALL be unchanged.
- overrun SHALL be set on that edge.
REQ-027 Simultaneous write and read when full: both SHALL complete; count stays DEPTH; the head advances.
REQ-028 Simultaneous write and read when empty: the read SHALL NOT fire (rd_valid=0); the write is accepted; count becomes 1.
REQ-029 overrun_clr=1 SHALL clear overrun on the next edge; a simultaneous new overrun event SHALL win (overrun stays 1).
REQ-030 rd_ready while empty SHALL have no effect.
REQ-031 Error flags SHALL be stored and delivered unmodified; the FIFO takes no action on them.

Reset
REQ-032 When rst_n=0, all of the following SHALL clear asynchronously: wr_ptr, rd_ptr, count, overrun.
REQ-033 Output values during reset: rd_valid=0, empty=1, full=0, count=0, overrun=0.
REQ-034 Storage contents SHALL NOT be reset; rd_data is don't-care while empty.
REQ-035 Reset mid-operation SHALL discard all held entries; the first write after release SHALL be the first read.

Structure
REQ-036 DATA_WIDTH and FIFO_DEPTH defaults SHALL come from the shared UART defines file used by the receiver blocks; no local literals.
REQ-037 The storage array SHALL be a sub-module rx_fifo_ram:
- Write port: one synchronous port.
- Read port: one asynchronous port.
REQ-038 Pointer, count and flag logic SHALL reside in rx_fifo.
REQ-039 rx_fifo SHALL attach to the receiver top as follows:
- wr_* inputs connect to the RX_DATA output and the PARITY_BIT_ERROR / STOP_BIT_ERROR outputs.
- wr_valid connects to the frame-done strobe.

Verification
REQ-040 Reset, then write 0xA5 with flags 0/0:
- Next cycle: rd_valid=1, rd_data=0xA5, count=1.
- rd_ready=1 for one cycle: empty=1, count=0.
REQ-041 Ordering and flags:
- Write 16 bytes 0x00..0x0F with rd_ready=0: full=1, count=16.
- Then drain: data returns in order 0x00..0x0F.
- Entry 0x03 was written with parity_err=1 and returns rd_parity_err=1.
REQ-042 Overrun:
- Fill to 16, then write 0xEE with rd_ready=0: overrun=1, count=16, and 0xEE never appears.
- Assert overrun_clr: overrun=0 the next cycle.
REQ-043 Full FIFO, write 0x55 with rd_ready=1 in the same cycle:
- count stays 16, overrun stays 0.
- After the remaining 15 reads, 0x55 is last out.
REQ-044 Empty FIFO, wr_valid and rd_ready together: count=1, rd_valid=1 next cycle.
REQ-045 Wrap and reset:
- Run 40 write/read pairs to wrap the pointers: data integrity holds.
- Assert rst_n=0 with count=5: count=0 and empty=1 immediately, no clock required.
